regfile_cmd_sequencer: RTL and testbench

- Command front-end for the 4x16 register file.
- Accepts whole read or write commands over a valid/ready handshake.
- Serialises each command onto the register file's shared 4-bit load bus (b), one-hot load select (p) and write strobe (r).
- For reads, samples the file's two combinational read outputs (w1, w2) and returns them on a valid/ready response channel.

---
 rtl/regfile_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_regfile_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_sequencer.sv
// regfile_cmd_sequencer: serialises whole read/write commands onto the 4x16
// register file's load bus (b), one-hot load select (p) and write strobe (r),
// and returns read results over a valid/ready response channel.
module regfile_cmd_sequencer #(
   parameter int unsigned READ_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic [3:0] b,
   output logic [3:0] p,
   output logic       r,
   input  logic [3:0] w1,
   input  logic [3:0] w2,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_d1,
   output logic [3:0] rsp_d2,
   output logic       busy
);

   localparam int unsigned DW = 4;
   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_WAIT);

   localparam logic [DW-1:0] P_RR1   = 4'b0001;
   localparam logic [DW-1:0] P_RR2   = 4'b0010;
   localparam logic [DW-1:0] P_WR    = 4'b0100;
   localparam logic [DW-1:0] P_WDATA = 4'b1000;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_W_ADDR = 4'd1,
      S_W_DATA = 4'd2,
      S_W_STRB = 4'd3,
      S_R_A    = 4'd4,
      S_R_B    = 4'd5,
      S_R_WAIT = 4'd6,
      S_R_SMP  = 4'd7,
      S_RESP   = 4'd8
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_d;
   logic [CW-1:0]   r_wait_cnt;
   logic [DW-1:0]   r_b;
   logic [DW-1:0]   r_p;
   logic            r_r;
   logic            r_cmd_ready;
   logic            r_busy;
   logic            r_rsp_valid;
   logic [DW-1:0]   r_rsp_d1;
   logic [DW-1:0]   r_rsp_d2;

   logic            w_accept;
   logic            w_capture;
   logic [DW-1:0]   w_a_nxt;
   logic [DW-1:0]   w_d_nxt;
   logic [DW-1:0]   w_b_nxt;
   logic [DW-1:0]   w_p_nxt;
   logic            w_r_nxt;

   assign w_accept  = cmd_valid && (r_state == S_IDLE);
   assign w_capture = (r_state == S_R_SMP);
   assign w_a_nxt   = w_accept ? cmd_a : r_a;
   assign w_d_nxt   = w_accept ? cmd_b : r_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = cmd_op ? S_W_ADDR : S_R_A;
         S_W_ADDR: w_state_nxt = S_W_DATA;
         S_W_DATA: w_state_nxt = S_W_STRB;
         S_W_STRB: w_state_nxt = S_IDLE;
         S_R_A:    w_state_nxt = S_R_B;
         S_R_B:    w_state_nxt = (WAIT_LOAD == '0) ? S_R_SMP : S_R_WAIT;
         S_R_WAIT: if (r_wait_cnt <= CW'(1)) w_state_nxt = S_R_SMP;
         S_R_SMP:  w_state_nxt = S_RESP;
         S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode for the state being entered, registered below
   always_comb begin
      w_b_nxt = '0;
      w_p_nxt = '0;
      w_r_nxt = 1'b0;
      case (w_state_nxt)
         S_W_ADDR: begin w_p_nxt = P_WR;    w_b_nxt = w_a_nxt; end
         S_W_DATA: begin w_p_nxt = P_WDATA; w_b_nxt = w_d_nxt; end
         S_W_STRB: w_r_nxt = 1'b1;
         S_R_A:    begin w_p_nxt = P_RR1;   w_b_nxt = w_a_nxt; end
         S_R_B:    begin w_p_nxt = P_RR2;   w_b_nxt = w_d_nxt; end
         default:  ;
      endcase
   end

   // Command operand capture on accept
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a <= '0;
         r_d <= '0;
      end else if (w_accept) begin
         r_a <= cmd_a;
         r_d <= cmd_b;
      end
   end

   // Settle-cycle down-counter, loaded on the way into R_WAIT
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_R_B) begin
         r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == S_R_WAIT) && (r_wait_cnt != '0)) begin
         r_wait_cnt <= r_wait_cnt - CW'(1);
      end
   end

   // Registered bus, handshake and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_b         <= '0;
         r_p         <= '0;
         r_r         <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_d1    <= '0;
         r_rsp_d2    <= '0;
      end else begin
         r_b         <= w_b_nxt;
         r_p         <= w_p_nxt;
         r_r         <= w_r_nxt;
         r_cmd_ready <= (w_state_nxt == S_IDLE);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_rsp_valid <= (w_state_nxt == S_RESP);
         if (w_capture) begin
            r_rsp_d1 <= w1;
            r_rsp_d2 <= w2;
         end
      end
   end

   assign b         = r_b;
   assign p         = r_p;
   assign r         = r_r;
   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp_valid;
   assign rsp_d1    = r_rsp_d1;
   assign rsp_d2    = r_rsp_d2;

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Bench for regfile_cmd_sequencer: a register-file model is attached to the bus,
// a reference memory predicts read data, and monitors check against queues.
module tb_regfile_cmd_sequencer;
   localparam int RW = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       cmd_valid, cmd_ready, cmd_op;
   logic [3:0] cmd_a, cmd_b, b, p, w1, w2, rsp_d1, rsp_d2;
   logic       r, rsp_valid, rsp_ready, busy;

   logic       cmd_valid_z, cmd_ready_z, cmd_op_z;
   logic [3:0] cmd_a_z, cmd_b_z, b_z, p_z, w1_z, w2_z, rsp_d1_z, rsp_d2_z;
   logic       r_z, rsp_valid_z, rsp_ready_z, busy_z;

   regfile_cmd_sequencer #(.READ_WAIT(RW)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .b(b), .p(p), .r(r),
      .w1(w1), .w2(w2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_d1(rsp_d1), .rsp_d2(rsp_d2), .busy(busy));

   regfile_cmd_sequencer #(.READ_WAIT(0)) u_dut_z (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid_z), .cmd_ready(cmd_ready_z),
      .cmd_op(cmd_op_z), .cmd_a(cmd_a_z), .cmd_b(cmd_b_z), .b(b_z), .p(p_z), .r(r_z),
      .w1(w1_z), .w2(w2_z), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
      .rsp_d1(rsp_d1_z), .rsp_d2(rsp_d2_z), .busy(busy_z));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file models: latches loaded from b by p, write on r
   logic [3:0] mem [16];
   logic [3:0] rr1 = 0, rr2 = 0, wr = 0, wd = 0;
   always @(posedge clk) begin
      if (p[0]) rr1 <= b;
      if (p[1]) rr2 <= b;
      if (p[2]) wr  <= b;
      if (p[3]) wd  <= b;
      if (r) mem[wr] <= wd;
   end
   assign w1 = mem[rr1];
   assign w2 = mem[rr2];

   logic [3:0] mem_z [16];
   logic [3:0] rr1_z = 0, rr2_z = 0, wr_z = 0, wd_z = 0;
   always @(posedge clk) begin
      if (p_z[0]) rr1_z <= b_z;
      if (p_z[1]) rr2_z <= b_z;
      if (p_z[2]) wr_z  <= b_z;
      if (p_z[3]) wd_z  <= b_z;
      if (r_z) mem_z[wr_z] <= wd_z;
   end
   assign w1_z = mem_z[rr1_z];
   assign w2_z = mem_z[rr2_z];

   // Reference model and expectation queues
   typedef struct { logic [3:0] a; logic [3:0] d; int e; } wexp_t;
   typedef struct { logic [3:0] d1; logic [3:0] d2; int e; } rexp_t;
   logic [3:0] ref_mem   [16];
   logic [3:0] ref_mem_z [16];
   wexp_t wq[$];
   rexp_t rq[$];
   rexp_t rq_z[$];

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Response handshake driver: 0 random, 1 forced low, 2 forced high
   int bp = 0;
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         rsp_ready = (bp == 1) ? 1'b0 : (bp == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) check("idle_timeout", int'(cmd_ready), 1);
   endtask

   // Issue one command; e returns the cycle number of the accepting edge
   task automatic issue(input bit op, input logic [3:0] a, input logic [3:0] d,
                        input bit hold, output int e);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = d;
      wait_idle();
      @(posedge clk); #1;
      e = cyc;
      if (op) begin
         ref_mem[a] = d;
         wq.push_back('{a: a, d: d, e: e});
      end else begin
         rq.push_back('{d1: ref_mem[a], d2: ref_mem[d], e: e});
      end
      check("ready_low_after_accept", int'(cmd_ready), 0);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic issue_z(input bit op, input logic [3:0] a, input logic [3:0] d);
      int n = 0;
      cmd_valid_z = 1'b1; cmd_op_z = op; cmd_a_z = a; cmd_b_z = d;
      while (!cmd_ready_z && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) check("idle_timeout_z", int'(cmd_ready_z), 1);
      @(posedge clk); #1;
      if (op) ref_mem_z[a] = d;
      else rq_z.push_back('{d1: ref_mem_z[a], d2: ref_mem_z[d], e: cyc});
      cmd_valid_z = 1'b0;
   endtask

   // Monitor: bus sequence, response data, latency and stability
   bit pv = 0;
   logic [3:0] pd1, pd2;
   always @(negedge clk) begin
      if (reset) begin
         pv = 0;
      end else begin
         if ($countones(p) > 1) check("p_multi_hot", int'(p), 0);
         if (p == 4'b0100) begin
            check("waddr_expected", int'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
               check("waddr_b", int'(b), int'(wq[0].a));
               check("waddr_cycle", cyc, wq[0].e);
            end
         end
         if (p == 4'b1000 && wq.size() != 0) begin
            check("wdata_b", int'(b), int'(wq[0].d));
            check("wdata_cycle", cyc, wq[0].e + 1);
         end
         if (r) begin
            check("strobe_expected", int'(wq.size() != 0), 1);
            check("strobe_p_zero", int'(p), 0);
            if (wq.size() != 0) begin
               check("strobe_cycle", cyc, wq[0].e + 2);
               void'(wq.pop_front());
            end
         end
         if (rsp_valid && !pv) begin
            check("rsp_expected", int'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               check("rsp_latency", cyc, rq[0].e + 3 + RW);
               check("rsp_d1", int'(rsp_d1), int'(rq[0].d1));
               check("rsp_d2", int'(rsp_d2), int'(rq[0].d2));
            end
         end
         if (rsp_valid && pv) begin
            check("rsp_d1_stable", int'(rsp_d1), int'(pd1));
            check("rsp_d2_stable", int'(rsp_d2), int'(pd2));
         end
         if (rsp_valid) check("ready_low_in_resp", int'(cmd_ready), 0);
         if (rsp_valid && rsp_ready && rq.size() != 0) void'(rq.pop_front());
         pv  = rsp_valid && !rsp_ready;
         pd1 = rsp_d1;
         pd2 = rsp_d2;
      end
   end

   // Monitor for the zero-wait instance
   always @(negedge clk) begin
      if (!reset && rsp_valid_z) begin
         check("z_rsp_expected", int'(rq_z.size() != 0), 1);
         if (rq_z.size() != 0) begin
            check("z_rsp_latency", cyc, rq_z[0].e + 3);
            check("z_rsp_d1", int'(rsp_d1_z), int'(rq_z[0].d1));
            check("z_rsp_d2", int'(rsp_d2_z), int'(rq_z[0].d2));
            void'(rq_z.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int e, e1, e2, e3, n;
      reset = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
      cmd_valid_z = 0; cmd_op_z = 0; cmd_a_z = 0; cmd_b_z = 0; rsp_ready_z = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_p", int'(p), 0);
      check("rst_b", int'(b), 0);
      check("rst_r", int'(r), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_d1", int'(rsp_d1), 0);
      check("rst_rsp_d2", int'(rsp_d2), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", int'(cmd_ready), 1);

      // Preload every register through the write path
      for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 4'($urandom_range(0, 15)), 1'b0, e);

      // Write then read back the same register on both ports
      issue(1'b1, 4'h5, 4'hA, 1'b0, e);
      issue(1'b0, 4'h5, 4'h5, 1'b0, e);

      // Read latency and cmd_ready low T+1..T+4+RW
      issue(1'b1, 4'h3, 4'h7, 1'b0, e);
      issue(1'b1, 4'h9, 4'hC, 1'b0, e);
      issue(1'b0, 4'h3, 4'h9, 1'b0, e);
      for (int k = 0; k < 4 + RW; k++) begin
         check("ready_low_read", int'(cmd_ready), 0);
         check("busy_high_read", int'(busy), 1);
         @(posedge clk); #1;
      end

      // Response backpressure with an ignored command
      wait_idle();
      bp = 1;
      issue(1'b0, 4'h9, 4'h3, 1'b0, e);
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("bp_rsp_seen", int'(rsp_valid), 1);
      repeat (6) begin
         cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 4'($urandom_range(0, 15));
         check("bp_valid_held", int'(rsp_valid), 1);
         check("bp_ready_low", int'(cmd_ready), 0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      bp = 2;
      @(posedge clk); #1;
      check("bp_idle_after_hs", int'(cmd_ready), 1);
      check("bp_valid_dropped", int'(rsp_valid), 0);
      bp = 0;

      // Back-to-back writes with cmd_valid held
      issue(1'b1, 4'h1, 4'h3, 1'b1, e1);
      issue(1'b1, 4'h2, 4'h6, 1'b1, e2);
      issue(1'b1, 4'hF, 4'h9, 1'b0, e3);
      check("b2b_spacing_1", e2 - e1, 4);
      check("b2b_spacing_2", e3 - e2, 4);
      issue(1'b0, 4'h1, 4'h2, 1'b0, e);
      issue(1'b0, 4'hF, 4'hF, 1'b0, e);

      // Reset during R_B aborts the read
      wait_idle();
      issue(1'b0, 4'h2, 4'h5, 1'b0, e);
      @(posedge clk); #1;
      check("in_r_b_p", int'(p), 4'b0010);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_p", int'(p), 0);
      check("abort_b", int'(b), 0);
      check("abort_rsp_valid", int'(rsp_valid), 0);
      check("abort_busy", int'(busy), 0);
      rq.delete();
      wq.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_ready", int'(cmd_ready), 1);
      check("abort_no_rsp", int'(rsp_valid), 0);
      issue(1'b0, 4'h2, 4'h5, 1'b0, e);

      // Randomized mix
      repeat (40) begin
         issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'b0, e);
      end

      // Zero-wait instance
      issue_z(1'b1, 4'h0, 4'h6);
      issue_z(1'b1, 4'hF, 4'hB);
      issue_z(1'b0, 4'h0, 4'hF);
      issue_z(1'b0, 4'hF, 4'h0);

      n = 0;
      while ((rq.size() != 0 || wq.size() != 0 || rq_z.size() != 0) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("drain_rq", rq.size(), 0);
      check("drain_wq", wq.size(), 0);
      check("drain_rq_z", rq_z.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
